// File: rtl/pool_pkg.sv
// Shared definitions for the pooled-feature writer.
// Mode and state encodings plus the lane compare helper.
package pool_pkg;

    localparam logic POOL_BYPASS = 1'b0;
    localparam logic POOL_MAX2   = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Widest sample a lane may carry through max2.
    localparam int MAXW = 64;

    // Max of two w-bit samples held zero-extended in MAXW bits.
    // Signed compare flips the sample MSB so one unsigned compare serves both.
    function automatic logic [MAXW-1:0] max2(
        input logic            sgn,
        input int              w,
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b
    );
        logic [MAXW-1:0] flip;
        logic [MAXW-1:0] ka;
        logic [MAXW-1:0] kb;
        flip = sgn ? (MAXW'(1) << (w - 1)) : '0;
        ka   = a ^ flip;
        kb   = b ^ flip;
        return (ka < kb) ? b : a;
    endfunction

endpackage

// File: rtl/pool_writer_if.sv
// Conv stream in, RAM port A/B out, for the pooled-feature writer.
// The writer uses the slave view; the producer side uses master.
interface pool_writer_if
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_CH          = 1,
    parameter int POOL_ADDR_WIDTH = 10
);

    logic                           conv_start;
    logic                           pool_mode;
    logic                           data_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_in;
    logic                           conv_done;

    logic                           busy;
    logic                           frame_done;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_a;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_b;
    logic [POOL_ADDR_WIDTH-1:0]     address_a_t;
    logic [POOL_ADDR_WIDTH-1:0]     address_b_t;
    logic                           wren_a;
    logic                           wren_b;
    logic                           rden_a;
    logic                           rden_b;

    modport master (
        output conv_start, pool_mode, data_valid, data_in, conv_done,
        input  busy, frame_done, data_a, data_b,
        input  address_a_t, address_b_t,
        input  wren_a, wren_b, rden_a, rden_b
    );

    modport slave (
        input  conv_start, pool_mode, data_valid, data_in, conv_done,
        output busy, frame_done, data_a, data_b,
        output address_a_t, address_b_t,
        output wren_a, wren_b, rden_a, rden_b
    );

endinterface

// File: rtl/pool_line_buf.sv
// Half-row line buffer holding horizontal maxima of even rows.
// One write port, one combinational read port.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store an even-row pair maximum; contents survive across frames.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pool_writer.sv
// CNN layer output stage: bypass or 2x2 max pooling into RAM port A.
// Valid-driven, multi-channel, abortable; port B is tied off.
module pool_writer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_CH          = 1,
    parameter int IMG_W           = 28,
    parameter int IMG_H           = 28,
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int SIGNED          = 1
) (
    input logic          clock,
    input logic          reset,
    pool_writer_if.slave bus
);

    localparam int WW  = NUM_CH * DATA_WIDTH;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LD  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int LW  = (LD > 1) ? $clog2(LD) : 1;
    localparam logic SGN = (SIGNED != 0);
    localparam int AWD = POOL_ADDR_WIDTH;

    logic [0:0]    state_q, state_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AWD-1:0] addr_q, addr_d;
    logic [WW-1:0] h_q, h_d;

    logic          wren_a_q, wren_a_d;
    logic          frame_done_q, frame_done_d;
    logic [WW-1:0] data_a_q, data_a_d;
    logic [AWD-1:0] address_a_q, address_a_d;

    logic          lb_we;
    logic [LW-1:0] lb_idx;
    logic [WW-1:0] lb_rd;
    logic [WW-1:0] hs_max;
    logic [WW-1:0] pool_res;

    logic          last_col;
    logic          last_row;
    logic          emit;
    logic [WW-1:0] res;

    assign lb_idx   = LW'(col_q >> 1);
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    pool_line_buf #(
        .WIDTH (WW),
        .DEPTH (LD),
        .AW    (LW)
    ) u_line_buf (
        .clock (clock),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (hs_max),
        .raddr (lb_idx),
        .rdata (lb_rd)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] h;
        logic [DATA_WIDTH-1:0] l;
        logic [DATA_WIDTH-1:0] m;

        assign s = bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign h = h_q[c*DATA_WIDTH +: DATA_WIDTH];
        assign l = lb_rd[c*DATA_WIDTH +: DATA_WIDTH];
        assign m = DATA_WIDTH'(max2(SGN, DATA_WIDTH,
                                    MAXW'(h), MAXW'(s)));

        assign hs_max[c*DATA_WIDTH +: DATA_WIDTH]   = m;
        assign pool_res[c*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(max2(SGN, DATA_WIDTH, MAXW'(l), MAXW'(m)));
    end

    // Frame FSM, pixel counters, pooling steps and next output word.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        h_d          = h_q;
        wren_a_d     = 1'b0;
        frame_done_d = 1'b0;
        data_a_d     = data_a_q;
        address_a_d  = address_a_q;
        lb_we        = 1'b0;
        emit         = 1'b0;
        res          = bus.data_in;

        if (bus.conv_done) begin
            // Abort wins over start and data, in either state.
            state_d = ST_IDLE;
        end else if (bus.conv_start) begin
            // Start, or restart a running frame dropping this sample.
            state_d = ST_RUN;
            mode_d  = bus.pool_mode;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
        end else if (state_q == ST_RUN && bus.data_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (last_col && last_row) begin
                state_d = ST_IDLE;
            end

            if (mode_q == POOL_BYPASS) begin
                emit = 1'b1;
            end else if (!col_q[0]) begin
                h_d = bus.data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                emit = 1'b1;
                res  = pool_res;
            end

            if (emit) begin
                wren_a_d     = 1'b1;
                data_a_d     = res;
                address_a_d  = addr_q;
                addr_d       = addr_q + 1'b1;
                frame_done_d = last_col && last_row;
            end
        end
    end

    // State and output register, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= POOL_BYPASS;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            h_q          <= '0;
            wren_a_q     <= 1'b0;
            frame_done_q <= 1'b0;
            data_a_q     <= '0;
            address_a_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            h_q          <= h_d;
            wren_a_q     <= wren_a_d;
            frame_done_q <= frame_done_d;
            data_a_q     <= data_a_d;
            address_a_q  <= address_a_d;
        end
    end

    assign bus.busy        = (state_q == ST_RUN);
    assign bus.frame_done  = frame_done_q;
    assign bus.wren_a      = wren_a_q;
    assign bus.data_a      = data_a_q;
    assign bus.address_a_t = address_a_q;
    assign bus.data_b      = '0;
    assign bus.address_b_t = '0;
    assign bus.wren_b      = 1'b0;
    assign bus.rden_a      = 1'b0;
    assign bus.rden_b      = 1'b0;

endmodule

// File: tb/tb_pool_writer.sv
// Scoreboard bench for pool_writer on a 4x4 image.
// Three instances: signed 1ch, unsigned 1ch, signed 2ch.
module tb_pool_writer;
    import pool_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 10;

    typedef struct {
        int             cyc;
        logic [AW-1:0]  addr;
        logic [31:0]    data;
        logic           fd;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        st = 1'b0;
    logic        md = 1'b0;
    logic        dv = 1'b0;
    logic        dn = 1'b0;
    logic [15:0] x16 = '0;
    logic [31:0] x32 = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit run_next = 1'b0;
    bit run_cur = 1'b0;

    exp_t q [3][$];
    logic [15:0] fr16 [N];
    logic [31:0] frc [N];
    logic [15:0] d16 [N];
    logic [31:0] d32 [N];
    int m_col = 0;
    int m_row = 0;
    logic [AW-1:0] m_addr = '0;
    logic m_mode = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        run_cur <= run_next;
    end

    pool_writer_if #(.DATA_WIDTH(16), .NUM_CH(1), .POOL_ADDR_WIDTH(AW)) bs ();
    pool_writer_if #(.DATA_WIDTH(16), .NUM_CH(1), .POOL_ADDR_WIDTH(AW)) bu ();
    pool_writer_if #(.DATA_WIDTH(16), .NUM_CH(2), .POOL_ADDR_WIDTH(AW)) bc ();

    assign bs.conv_start = st;
    assign bs.pool_mode  = md;
    assign bs.data_valid = dv;
    assign bs.conv_done  = dn;
    assign bs.data_in    = x16;
    assign bu.conv_start = st;
    assign bu.pool_mode  = md;
    assign bu.data_valid = dv;
    assign bu.conv_done  = dn;
    assign bu.data_in    = x16;
    assign bc.conv_start = st;
    assign bc.pool_mode  = md;
    assign bc.data_valid = dv;
    assign bc.conv_done  = dn;
    assign bc.data_in    = x32;

    pool_writer #(
        .DATA_WIDTH(16), .NUM_CH(1), .IMG_W(W), .IMG_H(H),
        .POOL_ADDR_WIDTH(AW), .SIGNED(1)
    ) dut_s (.clock(clock), .reset(reset), .bus(bs));

    pool_writer #(
        .DATA_WIDTH(16), .NUM_CH(1), .IMG_W(W), .IMG_H(H),
        .POOL_ADDR_WIDTH(AW), .SIGNED(0)
    ) dut_u (.clock(clock), .reset(reset), .bus(bu));

    pool_writer #(
        .DATA_WIDTH(16), .NUM_CH(2), .IMG_W(W), .IMG_H(H),
        .POOL_ADDR_WIDTH(AW), .SIGNED(1)
    ) dut_c (.clock(clock), .reset(reset), .bus(bc));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mx(input bit sg, input logic [15:0] a,
                                       input logic [15:0] b);
        if (sg) return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] mx4(input bit sg,
        input logic [15:0] a, input logic [15:0] b,
        input logic [15:0] c, input logic [15:0] d);
        return mx(sg, mx(sg, a, b), mx(sg, c, d));
    endfunction

    task automatic mon(input int k, input string tag, input logic wr,
                       input logic fd, input logic [31:0] data,
                       input logic [AW-1:0] addr, input logic busy);
        exp_t e;
        check({tag, "_busy"}, busy, run_cur);
        if (wr) begin
            if (q[k].size() == 0) begin
                check({tag, "_spurious_wr"}, wr, 1'b0);
            end else begin
                e = q[k].pop_front();
                check({tag, "_data"}, data, e.data);
                check({tag, "_addr"}, addr, e.addr);
                check({tag, "_cycle"}, cyc, e.cyc);
                check({tag, "_frame_done"}, fd, e.fd);
            end
        end else if (fd) begin
            check({tag, "_fd_without_wr"}, fd, 1'b0);
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            mon(0, "s", bs.wren_a, bs.frame_done, 32'(bs.data_a),
                bs.address_a_t, bs.busy);
            mon(1, "u", bu.wren_a, bu.frame_done, 32'(bu.data_a),
                bu.address_a_t, bu.busy);
            mon(2, "c", bc.wren_a, bc.frame_done, bc.data_a,
                bc.address_a_t, bc.busy);
        end
    end

    task automatic push_all(input logic [15:0] vs, input logic [15:0] vu,
                            input logic [31:0] vc, input logic fd);
        exp_t e;
        e.cyc  = cyc + 1;
        e.addr = m_addr;
        e.fd   = fd;
        e.data = 32'(vs);
        q[0].push_back(e);
        e.data = 32'(vu);
        q[1].push_back(e);
        e.data = vc;
        q[2].push_back(e);
        m_addr = m_addr + 1'b1;
    endtask

    task automatic model_accept(input logic [15:0] a16,
                                input logic [31:0] a32);
        int i;
        int a, b, c;
        logic last;
        logic [15:0] ps, pu, c0, c1;
        i = m_row * W + m_col;
        fr16[i] = a16;
        frc[i]  = a32;
        last = (m_col == W - 1) && (m_row == H - 1);
        if (m_mode == POOL_BYPASS) begin
            push_all(a16, a16, a32, last);
        end else if ((m_col % 2 == 1) && (m_row % 2 == 1)) begin
            a  = i - W - 1;
            b  = i - W;
            c  = i - 1;
            ps = mx4(1'b1, fr16[a], fr16[b], fr16[c], fr16[i]);
            pu = mx4(1'b0, fr16[a], fr16[b], fr16[c], fr16[i]);
            c0 = mx4(1'b1, frc[a][15:0], frc[b][15:0],
                     frc[c][15:0], frc[i][15:0]);
            c1 = mx4(1'b1, frc[a][31:16], frc[b][31:16],
                     frc[c][31:16], frc[i][31:16]);
            push_all(ps, pu, {c1, c0}, last);
        end
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        if (last) run_next = 1'b0;
    endtask

    task automatic step(input logic s_, input logic m_, input logic v_,
                        input logic d_, input logic [15:0] a16,
                        input logic [31:0] a32);
        @(posedge clock);
        #1;
        st  = s_;
        md  = m_;
        dv  = v_;
        dn  = d_;
        x16 = a16;
        x32 = a32;
        if (d_) begin
            run_next = 1'b0;
        end else if (s_) begin
            run_next = 1'b1;
            m_col    = 0;
            m_row    = 0;
            m_addr   = '0;
            m_mode   = m_;
        end else if (v_ && run_next) begin
            model_accept(a16, a32);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic run_frame(input logic m_, input bit gaps);
        step(1'b1, m_, 1'b1, 1'b0, 16'hDEAD, 32'hDEADBEEF);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(1, 0) == 1)
                repeat ($urandom_range(2, 1)) idle();
            step(1'b0, m_, 1'b1, 1'b0, d16[i], d32[i]);
        end
    endtask

    task automatic partial(input logic m_, input int n);
        step(1'b1, m_, 1'b0, 1'b0, 16'h0, 32'h0);
        for (int i = 0; i < n; i++)
            step(1'b0, m_, 1'b1, 1'b0, d16[i], d32[i]);
    endtask

    task automatic drain(input string tag);
        repeat (3) idle();
        check({tag, "_q_s_left"}, q[0].size(), 0);
        check({tag, "_q_u_left"}, q[1].size(), 0);
        check({tag, "_q_c_left"}, q[2].size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, bs.busy, 1'b0);
        check({tag, "_wren_a"}, bs.wren_a, 1'b0);
        check({tag, "_frame_done"}, bs.frame_done, 1'b0);
        check({tag, "_data_a"}, bs.data_a, 16'h0);
        check({tag, "_addr_a"}, bs.address_a_t, 10'h0);
        check({tag, "_data_b"}, bs.data_b, 16'h0);
        check({tag, "_addr_b"}, bs.address_b_t, 10'h0);
        check({tag, "_wren_b"}, bs.wren_b, 1'b0);
        check({tag, "_rden"}, {bs.rden_a, bs.rden_b}, 2'b00);
        check({tag, "_c_data_a"}, bc.data_a, 32'h0);
        check({tag, "_c_busy"}, bc.busy, 1'b0);
    endtask

    task automatic load_seq();
        for (int i = 0; i < N; i++) begin
            d16[i] = 16'(i);
            d32[i] = {16'(15 - i), 16'(i)};
        end
    endtask

    task automatic load_signed();
        for (int i = 0; i < N; i++) d16[i] = 16'hFFFB;
        d16[0] = 16'hFFFD;
        d16[1] = 16'h0002;
        d16[4] = 16'hFFF9;
        d16[5] = 16'hFFFF;
        for (int i = 0; i < N; i++) d32[i] = {~d16[i], d16[i]};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clock);
        check_idle("reset");

        load_seq();
        run_frame(POOL_BYPASS, 1'b0);
        drain("byp_seq");
        run_frame(POOL_MAX2, 1'b0);
        drain("max_seq");

        load_signed();
        run_frame(POOL_MAX2, 1'b0);
        drain("max_sgn");

        load_seq();
        run_frame(POOL_BYPASS, 1'b1);
        drain("byp_gap");
        run_frame(POOL_MAX2, 1'b1);
        drain("max_gap");
        load_signed();
        run_frame(POOL_MAX2, 1'b1);
        drain("sgn_gap");

        load_seq();
        partial(POOL_BYPASS, 6);
        step(1'b0, POOL_BYPASS, 1'b1, 1'b1, 16'h7777, 32'h7777_7777);
        drain("abort");
        run_frame(POOL_BYPASS, 1'b0);
        drain("after_abort");

        partial(POOL_MAX2, 7);
        run_frame(POOL_MAX2, 1'b0);
        drain("restart");

        partial(POOL_BYPASS, 5);
        @(posedge clock);
        #1;
        st = 1'b0;
        dv = 1'b0;
        dn = 1'b0;
        reset = 1'b1;
        run_next = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle("mid_reset");
        drain("mid_reset");

        run_frame(POOL_MAX2, 1'b0);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pool_writer.md
# pool_writer

Parametrised output stage for a CNN layer. It takes the convolution result stream, either passes each pixel straight through (bypass) or applies 2x2 stride-2 max pooling, and writes the result into the layer's dual-port pooled-feature RAM through port A. Port B is tied off. It replaces the fixed-cycle, single-channel, no-pool writer with a valid-driven, multi-channel, mode-selectable writer that can also abort a frame.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one channel sample
- NUM_CH, 1, parallel channels packed in one word (channel 0 in the LSBs)
- IMG_W, 28, conv output row length in pixels (must be even for pool mode)
- IMG_H, 28, conv output rows per frame (must be even for pool mode)
- POOL_ADDR_WIDTH, 10, RAM address width
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- conv_start  in  1  one-cycle pulse that starts a frame
- pool_mode  in  1  0 = bypass, 1 = max2x2; sampled on conv_start
- data_valid  in  1  data_in carries one conv pixel this cycle
- data_in  in  NUM_CH*DATA_WIDTH  conv pixel, all channels
- conv_done  in  1  abort; high ends the frame with no further writes
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse coinciding with the final write
- data_a / data_b  out  NUM_CH*DATA_WIDTH  write data; data_b = 0
- address_a_t / address_b_t  out  POOL_ADDR_WIDTH  write address; address_b_t = 0
- wren_a / wren_b  out  1  write strobe; wren_b = 0
- rden_a / rden_b  out  1  constant 0

## Operation
- States: IDLE and RUN.
- IDLE:
  - On conv_start: go to RUN, clear col, row and the address, latch pool_mode.
  - data_valid is ignored.
- RUN: each data_valid advances col.
  - col wraps at IMG_W-1, which increments row.
  - The last accepted sample (col = IMG_W-1, row = IMG_H-1) returns the block to IDLE.
- Bypass mode: every accepted sample produces one write of data_in.
- Max2x2 mode (all channels independently; comparison signedness per SIGNED):
  - Even col: register the sample as the horizontal candidate h.
  - Odd col, even row: store max(h, sample) in the line buffer at col/2 (IMG_W/2 entries).
  - Odd col, odd row: write max(linebuf[col/2], h, sample).
  - Result: IMG_W*IMG_H/4 writes per frame.
- Address:
  - Increments by 1 after each write and starts at 0 each frame.
  - Wraps modulo 2^POOL_ADDR_WIDTH with no flag.
- Priorities, highest first: reset > conv_done > conv_start > data_valid.
  - conv_done in RUN: return to IDLE next cycle and suppress any write that sample would cause.
  - frame_done is not pulsed on abort.
  - conv_start in RUN: restart the frame. Any sample in the same cycle is dropped.
- The line buffer is not cleared between frames; even rows always overwrite it before it is read.

## Timing
- Reset values:
  - busy 0, frame_done 0, wren_a 0.
  - data_a 0, address_a_t 0.
  - State IDLE, counters and candidates 0.
- Latency: accepted sample at edge N produces wren_a/data_a/address_a_t valid after edge N+1 (one registered stage), in both modes.
- busy:
  - Rises the cycle after conv_start.
  - Falls the cycle after the last sample is accepted, i.e. together with the final wren_a and frame_done.
- Throughput: one sample per clock sustained. Gaps in data_valid are allowed anywhere and stall the counters.
- wren_a is a single-cycle strobe per result. data_a/address_a_t hold their value between writes.

## Structure
- Shared package pool_pkg holds:
  - mode encodings POOL_BYPASS = 0 and POOL_MAX2 = 1
  - the state encoding
  - a max2 function parameterised on SIGNED
- Sub-module pool_line_buf: a simple register-array line buffer.
  - IMG_W/2 entries of NUM_CH*DATA_WIDTH.
  - One write port and one combinational read port.
- Top-level pool_writer contains the FSM, col/row/address counters, per-channel compare lanes (generate loop) and the output register.

## Test plan
All scenarios use IMG_W = 4, IMG_H = 4, NUM_CH = 1, DATA_WIDTH = 16 unless stated.
- Bypass, values 0..15 back-to-back:
  - Expect 16 writes, address 0..15, data equal to the input.
  - frame_done coincides with the write to address 15; busy low afterwards.
- Max2x2, values 0..15 row-major:
  - Expect 4 writes: address 0..3, data 5, 7, 13, 15.
  - frame_done with the 4th write.
- Max2x2, SIGNED = 1, block {-3, 2; -7, -1} plus the other blocks all -5:
  - First write is 2; the remaining writes are 0xFFFB.
  - Rerun with SIGNED = 0: first write is 0xFFFF.
- NUM_CH = 2, max2x2, ch0 = 0..15 and ch1 = 15..0:
  - Writes {ch1,ch0} = {15,5}, {13,7}, {7,13}, {5,15} in address order 0..3.
  - Checks channel independence.
- Random data_valid gaps (about 50% duty) in both modes:
  - Same data and addresses as the gap-free runs.
  - Each write lands exactly 1 cycle after the sample that completes it.
- Abort and restart:
  - conv_done after 6 bypass samples: 6 writes, no frame_done, busy low next cycle.
  - Later conv_start: the new frame begins again at address 0.
  - Synchronous reset mid-frame: all outputs return to their reset values on the next edge.
